// File: rtl/peripheral_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral bus between two bus masters.
// A grant is held for the whole transfer (while the owner keeps we/oe up). A busy watchdog
// force-completes a transfer when the peripheral holds busy too long.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   mN_we/oe/address/...        master N request side (N = 0, 1)
//   mN_busy, mN_dataRead        master N stall and read data
//   peripheralBus_*             shared downstream bus
//   timeoutClear                clears timeoutSticky
//   timeoutPulse                one cycle high after watchdog expiry
//   timeoutSticky               set on expiry, held until timeoutClear
//   timeoutMaster               master that timed out last
module peripheral_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned COUNTER_WIDTH  = 9
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_we,
    input  logic        m0_oe,
    input  logic [23:0] m0_address,
    input  logic [3:0]  m0_byteSelect,
    input  logic [31:0] m0_dataWrite,
    output logic        m0_busy,
    output logic [31:0] m0_dataRead,
    input  logic        m1_we,
    input  logic        m1_oe,
    input  logic [23:0] m1_address,
    input  logic [3:0]  m1_byteSelect,
    input  logic [31:0] m1_dataWrite,
    output logic        m1_busy,
    output logic [31:0] m1_dataRead,
    output logic        peripheralBus_we,
    output logic        peripheralBus_oe,
    output logic [23:0] peripheralBus_address,
    output logic [3:0]  peripheralBus_byteSelect,
    output logic [31:0] peripheralBus_dataWrite,
    input  logic        peripheralBus_busy,
    input  logic [31:0] peripheralBus_dataRead,
    input  logic        timeoutClear,
    output logic        timeoutPulse,
    output logic        timeoutSticky,
    output logic        timeoutMaster
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGrant0 = 2'b01,
        StGrant1 = 2'b10
    } state_e;

    localparam bit WatchdogOn = (TIMEOUT_CYCLES != 0);
    localparam logic [COUNTER_WIDTH-1:0] CountLast = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                   state_q, state_d;
    logic                     last_grant_q, last_grant_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic                     timed_out_q, timed_out_d;
    logic                     pulse_q, pulse_d;
    logic                     sticky_q, sticky_d;
    logic                     master_q, master_d;

    logic req0, req1;
    logic granted, grant_idx, busy_in_grant, expire, grant_change;

    assign req0 = m0_we | m0_oe;
    assign req1 = m1_we | m1_oe;

    assign granted       = (state_q == StGrant0) || (state_q == StGrant1);
    assign grant_idx     = (state_q == StGrant1);
    assign busy_in_grant = granted && peripheralBus_busy && !timed_out_q;
    assign expire        = WatchdogOn && busy_in_grant && (count_q == CountLast);
    assign grant_change  = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                // On a tie the master that did not go last wins.
                if (req0 && req1)  state_d = last_grant_q ? StGrant0 : StGrant1;
                else if (req0)     state_d = StGrant0;
                else if (req1)     state_d = StGrant1;
            end
            StGrant0: if (!req0) state_d = req1 ? StGrant1 : StIdle;
            StGrant1: if (!req1) state_d = req0 ? StGrant0 : StIdle;
            default:  state_d = StIdle; // illegal encoding recovers
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_d == StGrant0) last_grant_d = 1'b0;
        if (state_d == StGrant1) last_grant_d = 1'b1;

        count_d = count_q;
        if (grant_change || !granted) count_d = '0;
        else if (busy_in_grant)       count_d = count_q + 1'b1;

        // A release in the expiry cycle starts the next transfer clean.
        timed_out_d = timed_out_q;
        if (grant_change) timed_out_d = 1'b0;
        else if (expire)  timed_out_d = 1'b1;

        pulse_d = expire;

        sticky_d = sticky_q;
        if (expire)            sticky_d = 1'b1;
        else if (timeoutClear) sticky_d = 1'b0;

        master_d = expire ? grant_idx : master_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            count_q      <= '0;
            timed_out_q  <= 1'b0;
            pulse_q      <= 1'b0;
            sticky_q     <= 1'b0;
            master_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            timed_out_q  <= timed_out_d;
            pulse_q      <= pulse_d;
            sticky_q     <= sticky_d;
            master_q     <= master_d;
        end
    end

    always_comb begin
        peripheralBus_we         = 1'b0;
        peripheralBus_oe         = 1'b0;
        peripheralBus_address    = '0;
        peripheralBus_byteSelect = '0;
        peripheralBus_dataWrite  = '0;
        m0_busy                  = 1'b1;
        m1_busy                  = 1'b1;
        m0_dataRead              = '1;
        m1_dataRead              = '1;
        case (state_q)
            StGrant0: begin
                peripheralBus_we         = m0_we & ~timed_out_q;
                peripheralBus_oe         = m0_oe & ~timed_out_q;
                peripheralBus_address    = m0_address;
                peripheralBus_byteSelect = m0_byteSelect;
                peripheralBus_dataWrite  = m0_dataWrite;
                m0_busy                  = timed_out_q ? 1'b0 : peripheralBus_busy;
                m0_dataRead              = timed_out_q ? '1 : peripheralBus_dataRead;
            end
            StGrant1: begin
                peripheralBus_we         = m1_we & ~timed_out_q;
                peripheralBus_oe         = m1_oe & ~timed_out_q;
                peripheralBus_address    = m1_address;
                peripheralBus_byteSelect = m1_byteSelect;
                peripheralBus_dataWrite  = m1_dataWrite;
                m1_busy                  = timed_out_q ? 1'b0 : peripheralBus_busy;
                m1_dataRead              = timed_out_q ? '1 : peripheralBus_dataRead;
            end
            default: ;
        endcase
    end

    assign timeoutPulse  = pulse_q;
    assign timeoutSticky = sticky_q;
    assign timeoutMaster = master_q;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Bench for peripheral_bus_arbiter: transfer-level owner model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_peripheral_bus_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_we = 0, m0_oe = 0, m1_we = 0, m1_oe = 0;
    logic [23:0] m0_address = '0, m1_address = '0;
    logic [3:0]  m0_bs = '0, m1_bs = '0;
    logic [31:0] m0_dw = '0, m1_dw = '0;
    logic        m0_busy, m1_busy;
    logic [31:0] m0_dr, m1_dr;
    logic        pb_we, pb_oe;
    logic [23:0] pb_addr;
    logic [3:0]  pb_bs;
    logic [31:0] pb_dw;
    logic        pb_busy = 0;
    logic [31:0] pb_dr = '0;
    logic        tclr = 0;
    logic        tpulse, tsticky, tmaster;

    int total = 0;
    int bad = 0;

    peripheral_bus_arbiter #(.TIMEOUT_CYCLES(T), .COUNTER_WIDTH(9)) dut (
        .wb_clk_i                 (clk),
        .wb_rst_i                 (rst),
        .m0_we                    (m0_we),
        .m0_oe                    (m0_oe),
        .m0_address               (m0_address),
        .m0_byteSelect            (m0_bs),
        .m0_dataWrite             (m0_dw),
        .m0_busy                  (m0_busy),
        .m0_dataRead              (m0_dr),
        .m1_we                    (m1_we),
        .m1_oe                    (m1_oe),
        .m1_address               (m1_address),
        .m1_byteSelect            (m1_bs),
        .m1_dataWrite             (m1_dw),
        .m1_busy                  (m1_busy),
        .m1_dataRead              (m1_dr),
        .peripheralBus_we         (pb_we),
        .peripheralBus_oe         (pb_oe),
        .peripheralBus_address    (pb_addr),
        .peripheralBus_byteSelect (pb_bs),
        .peripheralBus_dataWrite  (pb_dw),
        .peripheralBus_busy       (pb_busy),
        .peripheralBus_dataRead   (pb_dr),
        .timeoutClear             (tclr),
        .timeoutPulse             (tpulse),
        .timeoutSticky            (tsticky),
        .timeoutMaster            (tmaster)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: who owns the bus, who went last, busy cycles seen in this transfer.
    int owner = -1;
    int last = 1;
    int busy_seen = 0;
    bit to_m = 0, pulse_m = 0, sticky_m = 0, tmaster_m = 0, model_ok = 0;
    bit r0, r1, expired;
    int nxt;

    always @(posedge clk) begin
        if (rst) begin
            owner = -1; last = 1; busy_seen = 0;
            to_m = 0; pulse_m = 0; sticky_m = 0; tmaster_m = 0; model_ok = 1;
        end else begin
            r0 = m0_we || m0_oe;
            r1 = m1_we || m1_oe;
            expired = (owner >= 0) && pb_busy && !to_m && (busy_seen + 1 == T);
            if (owner == -1) begin
                if (r0 && r1) nxt = 1 - last;
                else if (r0)  nxt = 0;
                else if (r1)  nxt = 1;
                else          nxt = -1;
            end else if ((owner == 0 && r0) || (owner == 1 && r1)) begin
                nxt = owner;
            end else if ((owner == 0 && r1) || (owner == 1 && r0)) begin
                nxt = 1 - owner;
            end else begin
                nxt = -1;
            end
            pulse_m = expired;
            if (expired) begin
                sticky_m = 1;
                tmaster_m = (owner == 1);
            end else if (tclr) begin
                sticky_m = 0;
            end
            if (nxt != owner) begin
                busy_seen = 0;
                to_m = 0;
            end else if (owner >= 0) begin
                if (pb_busy && !to_m) busy_seen++;
                if (expired) to_m = 1;
            end
            if (nxt >= 0) last = nxt;
            owner = nxt;
        end
    end

    logic        e_we, e_oe, e_b0, e_b1;
    logic [23:0] e_addr;
    logic [3:0]  e_bs;
    logic [31:0] e_dw, e_d0, e_d1;

    always @(negedge clk) begin
        if (model_ok) begin
            e_we = 0; e_oe = 0; e_addr = '0; e_bs = '0; e_dw = '0;
            e_b0 = 1; e_b1 = 1; e_d0 = '1; e_d1 = '1;
            if (owner == 0) begin
                e_we = m0_we && !to_m; e_oe = m0_oe && !to_m;
                e_addr = m0_address; e_bs = m0_bs; e_dw = m0_dw;
                e_b0 = to_m ? 1'b0 : pb_busy;
                e_d0 = to_m ? 32'hFFFF_FFFF : pb_dr;
            end else if (owner == 1) begin
                e_we = m1_we && !to_m; e_oe = m1_oe && !to_m;
                e_addr = m1_address; e_bs = m1_bs; e_dw = m1_dw;
                e_b1 = to_m ? 1'b0 : pb_busy;
                e_d1 = to_m ? 32'hFFFF_FFFF : pb_dr;
            end
            chk("bus_we", 32'(pb_we), 32'(e_we));
            chk("bus_oe", 32'(pb_oe), 32'(e_oe));
            chk("bus_addr", 32'(pb_addr), 32'(e_addr));
            chk("bus_bs", 32'(pb_bs), 32'(e_bs));
            chk("bus_dw", pb_dw, e_dw);
            chk("m0_busy", 32'(m0_busy), 32'(e_b0));
            chk("m1_busy", 32'(m1_busy), 32'(e_b1));
            chk("m0_dr", m0_dr, e_d0);
            chk("m1_dr", m1_dr, e_d1);
            chk("t_pulse", 32'(tpulse), 32'(pulse_m));
            chk("t_sticky", 32'(tsticky), 32'(sticky_m));
            chk("t_master", 32'(tmaster), 32'(tmaster_m));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        m0_we = 0; m0_oe = 0; m1_we = 0; m1_oe = 0; pb_busy = 0; tclr = 0;
        cyc();
        cyc();
        rst = 0;
    endtask

    initial begin
        // Reset state
        cyc();
        @(negedge clk);
        chk("lit_rst_m0_busy", 32'(m0_busy), 32'd1);
        chk("lit_rst_m1_busy", 32'(m1_busy), 32'd1);
        chk("lit_rst_m0_dr", m0_dr, 32'hFFFF_FFFF);
        chk("lit_rst_m1_dr", m1_dr, 32'hFFFF_FFFF);
        chk("lit_rst_sticky", 32'(tsticky), 32'd0);
        chk("lit_rst_pulse", 32'(tpulse), 32'd0);
        chk("lit_rst_master", 32'(tmaster), 32'd0);
        cyc();
        rst = 0;

        // Master 0 read alone
        m0_oe = 1; m0_address = 24'hABCDEF; m0_bs = 4'hF; pb_dr = 32'h1234_5678;
        @(negedge clk);
        chk("lit_rd_c0_busy", 32'(m0_busy), 32'd1);
        chk("lit_rd_c0_oe", 32'(pb_oe), 32'd0);
        cyc();
        @(negedge clk);
        chk("lit_rd_c1_oe", 32'(pb_oe), 32'd1);
        chk("lit_rd_c1_addr", 32'(pb_addr), 32'h00AB_CDEF);
        chk("lit_rd_c1_busy", 32'(m0_busy), 32'd0);
        chk("lit_rd_c1_dr", m0_dr, 32'h1234_5678);
        cyc();
        m0_oe = 0;
        cyc();
        @(negedge clk);
        chk("lit_rd_idle_busy", 32'(m0_busy), 32'd1);
        chk("lit_rd_idle_addr", 32'(pb_addr), 32'd0);

        // Simultaneous writes after reset: master 0 first, then master 1 back-to-back
        do_reset();
        m0_we = 1; m0_address = 24'h000100; m0_dw = 32'h1111_1111;
        m1_we = 1; m1_address = 24'h000200; m1_dw = 32'h2222_2222;
        @(negedge clk);
        chk("lit_tie_c0_m0busy", 32'(m0_busy), 32'd1);
        chk("lit_tie_c0_m1busy", 32'(m1_busy), 32'd1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            pb_busy = (i == 1);
            @(negedge clk);
            chk("lit_hold_addr", 32'(pb_addr), 32'h0000_0100);
            chk("lit_hold_dw", pb_dw, 32'h1111_1111);
            chk("lit_hold_m1busy", 32'(m1_busy), 32'd1);
            cyc();
        end
        m0_we = 0; pb_busy = 0;
        @(negedge clk);
        chk("lit_rel_m1busy", 32'(m1_busy), 32'd1);
        cyc();
        @(negedge clk);
        chk("lit_b2b_addr", 32'(pb_addr), 32'h0000_0200);
        chk("lit_b2b_we", 32'(pb_we), 32'd1);
        chk("lit_b2b_m1busy", 32'(m1_busy), 32'd0);
        cyc();
        m1_we = 0;
        cyc();
        @(negedge clk);
        chk("lit_b2b_idle_we", 32'(pb_we), 32'd0);

        // Alternating simultaneous requests: 0, 1, 0, 1
        do_reset();
        for (int r = 0; r < 4; r++) begin
            m0_oe = 1; m1_oe = 1;
            cyc();
            @(negedge clk);
            chk("lit_rr_m0busy", 32'(m0_busy), 32'(r % 2));
            chk("lit_rr_m1busy", 32'(m1_busy), 32'((r + 1) % 2));
            cyc();
            m0_oe = 0; m1_oe = 0;
            cyc();
        end

        // Watchdog on master 1
        do_reset();
        m1_we = 1; m1_address = 24'h00ABCD; pb_busy = 1; pb_dr = 32'hCAFE_F00D;
        cyc();
        for (int i = 1; i <= T; i++) begin
            @(negedge clk);
            chk("lit_wd_pulse_low", 32'(tpulse), 32'd0);
            chk("lit_wd_m1busy", 32'(m1_busy), 32'd1);
            cyc();
        end
        @(negedge clk);
        chk("lit_wd_pulse", 32'(tpulse), 32'd1);
        chk("lit_wd_sticky", 32'(tsticky), 32'd1);
        chk("lit_wd_master", 32'(tmaster), 32'd1);
        chk("lit_wd_m1busy0", 32'(m1_busy), 32'd0);
        chk("lit_wd_m1dr", m1_dr, 32'hFFFF_FFFF);
        chk("lit_wd_we", 32'(pb_we), 32'd0);
        cyc();
        @(negedge clk);
        chk("lit_wd_pulse_end", 32'(tpulse), 32'd0);
        chk("lit_wd_sticky_hold", 32'(tsticky), 32'd1);
        cyc();
        tclr = 1;
        cyc();
        tclr = 0;
        @(negedge clk);
        chk("lit_wd_cleared", 32'(tsticky), 32'd0);
        cyc();
        m1_we = 0; pb_busy = 0;
        cyc();
        cyc();

        // Reset mid-write
        do_reset();
        m0_we = 1; m0_address = 24'h000055; pb_busy = 1;
        cyc();
        @(negedge clk);
        chk("lit_mid_we", 32'(pb_we), 32'd1);
        cyc();
        rst = 1;
        cyc();
        @(negedge clk);
        chk("lit_mid_we0", 32'(pb_we), 32'd0);
        chk("lit_mid_m0busy", 32'(m0_busy), 32'd1);
        chk("lit_mid_addr", 32'(pb_addr), 32'd0);
        cyc();
        rst = 0; m0_we = 0; pb_busy = 0;
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
